// File: rtl/pool_feeder_if.sv
// Conv->pooling link bundle: buffer read port plus the sample/enable lines toward POOLING.
// The feeder is the master side; buffer and POOLING together form the slave side.
interface pool_feeder_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          en_reg;
  logic          en_pooling;
  logic [DW-1:0] conv_out;
  logic          conv_valid;
  logic          done_pooling;

  modport master (
    output mem_rd, mem_addr, en_reg, en_pooling, conv_out, conv_valid,
    input  mem_rdata, done_pooling
  );

  modport slave (
    input  mem_rd, mem_addr, en_reg, en_pooling, conv_out, conv_valid,
    output mem_rdata, done_pooling
  );
endinterface

// File: rtl/pool_feeder.sv
// Streams a ROWS x LEN feature map from a registered-read buffer to POOLING with per-row gaps,
// then hands over via en_pooling and waits (with timeout) for done_pooling.
module pool_feeder #(
  parameter int unsigned DW      = 16,
  parameter int unsigned LEN     = 8,
  parameter int unsigned ROWS    = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned AW      = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  pool_feeder_if.master bus
);
  localparam int unsigned CW = $clog2(LEN + 1);
  localparam int unsigned RW = $clog2(ROWS + 1);
  localparam int unsigned GW = $clog2(GAP + 3);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_GAP, S_POOL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          en_reg_q, en_reg_d;
  logic          en_pool_q, en_pool_d;
  logic          busy_d, done_d, err_d;
  logic          pipe_q, pipe_d;
  logic          cv_q, cv_d;
  logic [DW-1:0] out_q, out_d;

  assign bus.mem_rd     = rd_q;
  assign bus.mem_addr   = addr_q;
  assign bus.en_reg     = en_reg_q;
  assign bus.en_pooling = en_pool_q;
  assign bus.conv_out   = out_q;
  assign bus.conv_valid = cv_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      en_reg_q  <= 1'b0;
      en_pool_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pipe_q    <= 1'b0;
      cv_q      <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      en_reg_q  <= en_reg_d;
      en_pool_q <= en_pool_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      pipe_q    <= pipe_d;
      cv_q      <= cv_d;
      out_q     <= out_d;
    end
  end

  // The FSM schedules reads; samples follow two cycles later through the pipe/capture stage.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    rd_d      = 1'b0;
    addr_d    = addr_q;
    en_reg_d  = en_reg_q;
    en_pool_d = en_pool_q;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pipe_d    = rd_q;
    cv_d      = pipe_q;
    out_d     = pipe_q ? bus.mem_rdata : out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !done && !err) begin
          state_d = S_PRIME;
          rd_d    = 1'b1;
          addr_d  = '0;
          col_d   = CW'(1);
          row_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_PRIME, S_STREAM: begin
        if (state_q == S_PRIME) begin
          en_reg_d = 1'b1;
          state_d  = S_STREAM;
        end
        if (col_q != CW'(LEN)) begin
          rd_d   = 1'b1;
          addr_d = addr_q + AW'(1);
          col_d  = col_q + CW'(1);
        end else if (row_q == RW'(ROWS - 1)) begin
          // Last row: idle for the gap plus the two cycles the read pipe needs to drain.
          state_d = S_GAP;
          gcnt_d  = GW'(GAP + 1);
        end else if (GAP == 0) begin
          rd_d   = 1'b1;
          addr_d = addr_q + AW'(1);
          col_d  = CW'(1);
          row_d  = row_q + RW'(1);
        end else begin
          state_d = S_GAP;
          gcnt_d  = GW'(GAP - 1);
        end
      end
      S_GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (row_q == RW'(ROWS - 1)) begin
          state_d   = S_POOL;
          en_reg_d  = 1'b0;
          en_pool_d = 1'b1;
          tcnt_d    = '0;
        end else begin
          state_d = S_STREAM;
          rd_d    = 1'b1;
          addr_d  = addr_q + AW'(1);
          col_d   = CW'(1);
          row_d   = row_q + RW'(1);
        end
      end
      S_POOL: begin
        if (bus.done_pooling) begin
          state_d   = S_IDLE;
          en_pool_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          en_pool_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else if (tcnt_q != TW'(TIMEOUT)) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pool_feeder.sv
// Directed, table-driven check of pool_feeder: per-edge expectations plus a running
// scoreboard of read addresses and streamed samples against a registered-read buffer model.
module tb_pool_feeder;
  localparam int unsigned DW = 16, LEN = 8, ROWS = 8, GAP = 2, AW = 6, TIMEOUT = 16;
  localparam int N = ROWS * LEN;
  localparam int LAST_ED = 222;

  logic clk = 1'b0;
  logic reset_n, start, busy, done, err;

  pool_feeder_if #(.DW(DW), .AW(AW)) bus ();

  pool_feeder #(.DW(DW), .LEN(LEN), .ROWS(ROWS), .GAP(GAP), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .err(err),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  typedef struct {
    int ed;
    logic st, dp, rn, chk;
    logic busy, done, err, er, ep, cv, rd;
    logic [DW-1:0] out;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0, n_bad = 0;
  int exp_addr = 0, exp_k = 0, n_done = 0, n_err = 0;
  logic st, dp, rn;

  task automatic cmp(input string name, input int ed, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, ed, act, exp);
    end
  endtask

  task automatic add_stim(input int ed, input logic s, input logic d, input logic r);
    vec_t v;
    v = '{ed: ed, st: s, dp: d, rn: r, chk: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0,
          er: 1'b0, ep: 1'b0, cv: 1'b0, rd: 1'b0, out: '0, addr: '0};
    tbl.push_back(v);
  endtask

  task automatic add_chk(input int ed, input logic b, input logic dn, input logic e,
                         input logic er, input logic ep, input logic cv, input int out,
                         input logic rd, input int addr);
    vec_t v;
    v = '{ed: ed, st: 1'b0, dp: 1'b0, rn: 1'b1, chk: 1'b1, busy: b, done: dn, err: e,
          er: er, ep: ep, cv: cv, rd: rd, out: DW'(out), addr: AW'(addr)};
    tbl.push_back(v);
  endtask

  task automatic check_row(input vec_t v);
    cmp("busy",       v.ed, int'(busy),           int'(v.busy));
    cmp("done",       v.ed, int'(done),           int'(v.done));
    cmp("err",        v.ed, int'(err),            int'(v.err));
    cmp("en_reg",     v.ed, int'(bus.en_reg),     int'(v.er));
    cmp("en_pooling", v.ed, int'(bus.en_pooling), int'(v.ep));
    cmp("conv_valid", v.ed, int'(bus.conv_valid), int'(v.cv));
    cmp("conv_out",   v.ed, int'(bus.conv_out),   int'(v.out));
    cmp("mem_rd",     v.ed, int'(bus.mem_rd),     int'(v.rd));
    cmp("mem_addr",   v.ed, int'(bus.mem_addr),   int'(v.addr));
  endtask

  // Every read must be the next address in order; every sample the next buffer word.
  task automatic scoreboard(input int ed);
    if (bus.mem_rd) begin
      if (exp_addr < N) cmp("addr_seq", ed, int'(bus.mem_addr), exp_addr);
      else              cmp("extra_read", ed, exp_addr, N - 1);
      exp_addr++;
    end
    if (bus.conv_valid) begin
      if (exp_k < N) cmp("sample_seq", ed, int'(bus.conv_out), int'(mem[exp_k]));
      else           cmp("extra_sample", ed, exp_k, N - 1);
      exp_k++;
    end
    if (done || err) begin
      cmp("read_count", ed, exp_addr, N);
      cmp("sample_count", ed, exp_k, N);
    end
    n_done += int'(done);
    n_err  += int'(err);
    if (!busy) begin
      exp_addr = 0;
      exp_k    = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    bus.done_pooling = 1'b0;
    for (int k = 0; k < N; k++) mem[k] = DW'(k + 1);

    // Run 1: start at edge 0, ignored starts at 5 and 50, done_pooling 5 cycles after en_pooling.
    add_chk(-1, 0,0,0, 0,0,0,  0, 0, 0);
    add_stim(-1, 1, 0, 1);
    add_chk(  0, 1,0,0, 0,0,0,  0, 1, 0);
    add_chk(  1, 1,0,0, 1,0,0,  0, 1, 1);
    add_chk(  2, 1,0,0, 1,0,1,  1, 1, 2);
    add_chk(  4, 1,0,0, 1,0,1,  3, 1, 4);
    add_stim( 4, 1, 0, 1);
    add_chk(  5, 1,0,0, 1,0,1,  4, 1, 5);
    add_chk(  9, 1,0,0, 1,0,1,  8, 0, 7);
    add_chk( 10, 1,0,0, 1,0,0,  8, 1, 8);
    add_chk( 11, 1,0,0, 1,0,0,  8, 1, 9);
    add_chk( 12, 1,0,0, 1,0,1,  9, 1, 10);
    add_chk( 19, 1,0,0, 1,0,1, 16, 0, 15);
    add_chk( 49, 1,0,0, 1,0,1, 40, 0, 39);
    add_stim(49, 1, 0, 1);
    add_chk( 50, 1,0,0, 1,0,0, 40, 1, 40);
    add_chk( 79, 1,0,0, 1,0,1, 64, 0, 63);
    add_chk( 81, 1,0,0, 1,0,0, 64, 0, 63);
    add_chk( 82, 1,0,0, 0,1,0, 64, 0, 63);
    add_chk( 87, 1,0,0, 0,1,0, 64, 0, 63);
    add_stim(87, 0, 1, 1);
    add_chk( 88, 0,1,0, 0,0,0, 64, 0, 63);
    add_stim(88, 1, 0, 1);
    add_chk( 89, 0,0,0, 0,0,0, 64, 0, 63);
    add_stim(89, 1, 0, 1);
    // Run 2: accepted at edge 90, aborted by reset at edge 120.
    add_chk( 90, 1,0,0, 0,0,0, 64, 1, 0);
    add_chk( 91, 1,0,0, 1,0,0, 64, 1, 1);
    add_chk( 92, 1,0,0, 1,0,1,  1, 1, 2);
    add_chk(119, 1,0,0, 1,0,1, 24, 0, 23);
    add_stim(119, 0, 0, 0);
    add_chk(120, 0,0,0, 0,0,0,  0, 0, 0);
    add_chk(121, 0,0,0, 0,0,0,  0, 0, 0);
    add_stim(121, 1, 0, 1);
    // Run 3: starts at edge 122, stray done_pooling while streaming, then times out.
    add_chk(122, 1,0,0, 0,0,0,  0, 1, 0);
    add_chk(124, 1,0,0, 1,0,1,  1, 1, 2);
    add_chk(149, 1,0,0, 1,0,1, 22, 1, 23);
    add_stim(149, 0, 1, 1);
    add_chk(150, 1,0,0, 1,0,1, 23, 0, 23);
    add_chk(203, 1,0,0, 1,0,0, 64, 0, 63);
    add_chk(204, 1,0,0, 0,1,0, 64, 0, 63);
    add_chk(219, 1,0,0, 0,1,0, 64, 0, 63);
    add_chk(220, 0,0,1, 0,0,0, 64, 0, 63);
    add_chk(221, 0,0,0, 0,0,0, 64, 0, 63);

    repeat (3) @(posedge clk);
    #1;
    for (int ed = -1; ed <= LAST_ED; ed++) begin
      if (ed >= 0) tick();
      st = 1'b0;
      dp = 1'b0;
      rn = 1'b1;
      foreach (tbl[i]) begin
        if (tbl[i].ed == ed) begin
          if (tbl[i].chk) check_row(tbl[i]);
          else begin
            st = tbl[i].st;
            dp = tbl[i].dp;
            rn = tbl[i].rn;
          end
        end
      end
      scoreboard(ed);
      start = st;
      bus.done_pooling = dp;
      reset_n = rn;
    end
    cmp("done_pulses", LAST_ED, n_done, 1);
    cmp("err_pulses", LAST_ED, n_err, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
